dac_stream_ctrl: RTL
====================

// Module: dac_stream_ctrl
// PURPOSE
//  Paces an audio sample stream into the hybrid PWM/sigma-delta DAC (d input) at a programmable rate.
//  Buffers incoming samples in a small FIFO and holds the last sample on underrun.
//  Ramps the DAC input between 0 and midscale on enable/disable to suppress start/stop pops.
//  Sits between the audio source (valid/ready stream) and the DAC instance.
// PARAMETERS
//  signalwidth   16  sample and DAC input width, unsigned offset-binary
//  fifo_log2     3   FIFO depth = 2**fifo_log2 entries
//  divwidth      16  width of the sample-rate divisor
//  rampstep      64  dac_d change per sample tick while ramping
// PORTS
//  clk           in   1                 clock
//  reset_n       in   1                 asynchronous, active-low reset
//  enable        in   1                 level; 1 = play, 0 = ramp down and park
//  divisor       in   divwidth          sample tick period in clk cycles, minus 1 (0 = tick every cycle)
//  s_data        in   signalwidth       input sample
//  s_valid       in   1                 s_data valid
//  s_ready       out  1                 FIFO accepts s_data this cycle
//  dac_d         out  signalwidth       registered value to DAC d input
//  running       out  1                 state == RUN
//  underrun      out  1                 one-cycle pulse: tick in RUN with FIFO empty
//  underrun_cnt  out  8                 saturating underrun count; cleared on IDLE->RAMP_UP
//  fifo_level    out  fifo_log2+1       current FIFO occupancy
// BEHAVIOUR
//  Reset: state IDLE, dac_d=0, FIFO empty, s_ready=0, running=0, underrun=0, underrun_cnt=0, tick counter=0.
//  Tick: down-counter; on 0, assert tick for 1 cycle and reload from divisor (sampled at reload).
//   The counter runs in all states. A divisor change takes effect at the next reload.
//  MID = 1<<(signalwidth-1). A step toward a target T is dac_d +/- min(rampstep, |T-dac_d|), computed without overflow.
//  States (2-bit):
//   IDLE:      dac_d holds. enable=1 -> RAMP_UP and clear underrun_cnt.
//   RAMP_UP:   on tick, step toward MID. When dac_d==MID after the update -> RUN.
//              enable=0 -> RAMP_DOWN, checked before tick handling.
//   RUN:       on tick, if FIFO non-empty, pop into dac_d (dac_d updates on the cycle after tick).
//              Otherwise hold dac_d, pulse underrun, and increment underrun_cnt (saturate at 255).
//              enable=0 -> RAMP_DOWN.
//   RAMP_DOWN: FIFO flushed on entry (level=0 next cycle). On tick, step toward 0. dac_d==0 -> IDLE.
//              enable=1 -> RAMP_UP from the current dac_d, with no jump.
//  s_ready = (state==RAMP_UP || state==RUN) && !full. A push occurs when s_valid && s_ready.
//   Full FIFO plus a pop in the same cycle: no push; s_ready does not depend on the pop.
//   Empty FIFO plus a push in the same cycle as a tick: underrun is reported; the new sample is stored, not bypassed.
//  Samples pushed during RAMP_UP are buffered and played from RUN entry.
//  Reset mid-operation: immediate return to reset values; FIFO contents discarded.
//  All outputs are registered except s_ready and fifo_level, which are decoded from registered state only.
// STRUCTURE
//  Shared header dac_ctrl_defs.vh: state encodings (IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3) and the MID macro.
//  One sub-module, sync_fifo #(width, depth_log2): push/pop/flush, full/empty/level, read data valid in the pop cycle.
//  Top level contains the tick divider, state machine, ramp arithmetic and underrun counter.
// TESTING
//  1. Startup: reset, divisor=3, enable=1, no data.
//     dac_d rises 0,64,128,... every 4 clks; running=1 when dac_d==32768 (512 ticks).
//  2. Play: in RUN, push 0x1234, 0xABCD.
//     dac_d takes 0x1234 then 0xABCD on consecutive ticks; s_ready=1 throughout.
//  3. Underrun: FIFO empty at a tick in RUN.
//     underrun high for exactly 1 clk, dac_d holds, underrun_cnt +1; 300 underruns -> cnt stays at 255.
//  4. Full: divisor=1000, push 9 samples back-to-back.
//     s_ready=0 after 8; fifo_level=8; 9th sample accepted only after a pop.
//  5. Shutdown: dac_d=0xFFF0, FIFO level 5, enable=0.
//     fifo_level=0 next clk; dac_d steps down by 64 per tick to 0, then IDLE. Re-enable midway -> ramp back up without a jump.
//  6. Async reset asserted mid-RUN with FIFO non-empty: all outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/dac_stream_ctrl_pkg.sv
// Shared state encoding, midscale helper and no-overshoot ramp arithmetic
// for the DAC stream controller.
package dac_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  function automatic logic [31:0] mid_code(input int width);
    return 32'd1 << (width - 1);
  endfunction

  // Moves cur toward tgt by at most step; the difference is taken before the
  // add/subtract, so the result never wraps past the target.
  function automatic logic [31:0] ramp_step(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
    if (cur < tgt) return ((tgt - cur) > step) ? (cur + step) : tgt;
    return ((cur - tgt) > step) ? (cur - step) : tgt;
  endfunction

endpackage

// File: rtl/dac_stream_ctrl_sync_fifo.sv
// Synchronous FIFO: push/pop/flush, read data valid combinationally in the pop cycle.
// Writes land one clk after push; a push while full or a pop while empty is ignored.
module dac_stream_ctrl_sync_fifo #(
  parameter int width      = 16,
  parameter int depth_log2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [width-1:0]      wr_dat,
  output logic [width-1:0]      rd_dat,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level
);

  logic [width-1:0]      mem [2**depth_log2];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Occupancy never exceeds 2**depth_log2, so the MSB alone marks full.
  assign full    = level[depth_log2];
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + depth_log2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + depth_log2'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + (depth_log2 + 1)'(1);
        2'b01:   level <= level - (depth_log2 + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/dac_stream_ctrl.sv
// Paces buffered audio samples into the DAC at divisor+1 clks per sample, ramping to/from midscale.
// dac_d updates the clk after a tick; s_ready drops when the FIFO is full or outside RAMP_UP/RUN.
module dac_stream_ctrl
  import dac_stream_ctrl_pkg::*;
#(
  parameter int signalwidth = 16,
  parameter int fifo_log2   = 3,
  parameter int divwidth    = 16,
  parameter int rampstep    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [divwidth-1:0]    divisor,
  input  logic [signalwidth-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [signalwidth-1:0] dac_d,
  output logic                   running,
  output logic                   underrun,
  output logic [7:0]             underrun_cnt,
  output logic [fifo_log2:0]     fifo_level
);

  localparam logic [signalwidth-1:0] MID = signalwidth'(mid_code(signalwidth));

  state_t                 state;
  state_t                 state_nxt;
  logic [divwidth-1:0]    tick_cnt;
  logic                   tick;
  logic [signalwidth-1:0] dac_nxt;
  logic [signalwidth-1:0] step_up;
  logic [signalwidth-1:0] step_dn;
  logic [signalwidth-1:0] fifo_rd_dat;
  logic                   fifo_pop;
  logic                   fifo_flush;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   underrun_nxt;
  logic                   cnt_clr;

  assign tick    = (tick_cnt == '0);
  assign step_up = signalwidth'(ramp_step(32'(dac_d), 32'(MID), 32'(rampstep)));
  assign step_dn = signalwidth'(ramp_step(32'(dac_d), 32'd0, 32'(rampstep)));
  assign s_ready = ((state == RAMP_UP) || (state == RUN)) && !fifo_full;

  dac_stream_ctrl_sync_fifo #(
    .width      (signalwidth),
    .depth_log2 (fifo_log2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (s_valid && s_ready),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_dat  (s_data),
    .rd_dat  (fifo_rd_dat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_nxt    = state;
    dac_nxt      = dac_d;
    fifo_pop     = 1'b0;
    underrun_nxt = 1'b0;
    cnt_clr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RAMP_UP;
          cnt_clr   = 1'b1;
        end
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else begin
          if (tick) dac_nxt = step_up;
          if (dac_nxt == MID) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dac_nxt  = fifo_rd_dat;
          end else begin
            underrun_nxt = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        // Re-enabling resumes from the current dac_d, so there is no step discontinuity.
        if (enable) begin
          state_nxt = RAMP_UP;
        end else begin
          if (tick) dac_nxt = step_dn;
          if (dac_nxt == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    fifo_flush = (state_nxt == RAMP_DOWN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dac_d        <= '0;
      tick_cnt     <= '0;
      running      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dac_d    <= dac_nxt;
      tick_cnt <= tick ? divisor : (tick_cnt - divwidth'(1));
      running  <= (state_nxt == RUN);
      underrun <= underrun_nxt;
      if (cnt_clr)
        underrun_cnt <= '0;
      else if (underrun_nxt && (underrun_cnt != 8'hFF))
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule
